// File: rtl/set_assoc_cache_ctrl_pkg.sv
// Shared types and elaboration helpers for the set-associative cache controller:
// FSM state enum, address-field width derivation and tree-PLRU victim/update rules.
package set_assoc_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int off_w(input int line_words);
    return 2 + clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - idx_w(sets) - off_w(line_words);
  endfunction

  // Bits point at the victim: bit0 selects the pair (4-way) or the way (2-way),
  // bit1/bit2 select within the left/right pair.
  function automatic logic [1:0] plru_victim(input int ways, input logic [2:0] bits);
    if (ways == 2) return {1'b0, bits[0]};
    return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  endfunction

  function automatic logic [2:0] plru_update(input int ways, input logic [2:0] bits,
                                             input logic [1:0] way);
    logic [2:0] nb;
    nb = bits;
    if (ways == 2) begin
      nb[0] = ~way[0];
    end else begin
      nb[0] = ~way[1];
      if (way[1]) nb[2] = ~way[0];
      else        nb[1] = ~way[0];
    end
    return nb;
  endfunction

endpackage

// File: rtl/set_assoc_cache_ctrl_if.sv
// Core-side request/response and SRAM-side fill/write-through signals of the cache.
interface set_assoc_cache_ctrl_if #(
  parameter int LINE_WORDS = 2
);
  // Core: read_en/write_en and their address/data are held stable until a cycle
  // with ready=1, which completes the request. SRAM: sram_read_en/sram_write_en
  // stay high with stable address/data until a cycle with sram_ready=1.
  logic                      read_en;
  logic                      write_en;
  logic [31:0]               address;
  logic [31:0]               write_data;
  logic                      ready;
  logic [31:0]               output_data;
  logic                      sram_read_en;
  logic                      sram_write_en;
  logic [31:0]               sram_address;
  logic [31:0]               sram_write_data;
  logic [32*LINE_WORDS-1:0]  sram_read_data;
  logic                      sram_ready;

  modport master (
    output read_en, write_en, address, write_data, sram_read_data, sram_ready,
    input  ready, output_data, sram_read_en, sram_write_en, sram_address, sram_write_data
  );

  modport slave (
    input  read_en, write_en, address, write_data, sram_read_data, sram_ready,
    output ready, output_data, sram_read_en, sram_write_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/set_assoc_cache_ctrl_plru.sv
// Per-set tree pseudo-LRU storage; reports the replacement way for the addressed set.
module cache_plru
  import set_assoc_cache_ctrl_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim
);

  logic [2:0] bits_q [SETS];

  assign victim = WAY_W'(plru_victim(WAYS, bits_q[idx]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else if (touch) begin
      bits_q[idx] <= plru_update(WAYS, bits_q[idx], 2'(touch_way));
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-through read cache with tree-PLRU replacement.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module set_assoc_cache_ctrl
  import set_assoc_cache_ctrl_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_W     = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  set_assoc_cache_ctrl_if.slave bus,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
`endif
  output state_e               state_dbg
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int WAY_W  = clog2(WAYS);
  localparam int WSEL_W = clog2(LINE_WORDS);
  localparam int LINE_W = 32 * LINE_WORDS;

  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [LINE_W-1:0] data_arr [WAYS][SETS];
  logic [SETS-1:0]   valid_q  [WAYS];

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] wsel;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, plru_way, victim;
  logic              touch, fill_we, wr_hit_we;
  logic [WAY_W-1:0]  touch_way;
  logic [LINE_W-1:0] hit_line;

  assign wsel      = bus.address[OFF_W-1:2];
  assign idx       = bus.address[OFF_W +: IDX_W];
  assign tag       = bus.address[ADDR_W-1:OFF_W+IDX_W];
  assign state_dbg = state_q;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && tag_arr[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; PLRU only decides once the set is full.
  always_comb begin
    victim = plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) victim = WAY_W'(w);
    end
  end

  assign hit_line = data_arr[hit_way][idx];

  cache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .touch     (touch),
    .touch_way (touch_way),
    .victim    (plru_way)
  );

  always_comb begin
    state_d             = state_q;
    bus.ready           = 1'b0;
    bus.output_data     = '0;
    bus.sram_read_en    = 1'b0;
    bus.sram_write_en   = 1'b0;
    bus.sram_address    = bus.address;
    bus.sram_write_data = bus.write_data;
    touch               = 1'b0;
    touch_way           = hit_way;
    fill_we             = 1'b0;
    wr_hit_we           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.write_en) begin
          state_d   = ST_WRITE;
          wr_hit_we = hit;
          touch     = hit;
        end else if (bus.read_en) begin
          if (hit) begin
            bus.ready       = 1'b1;
            bus.output_data = hit_line[32*wsel +: 32];
            touch           = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = {bus.address[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.sram_ready) begin
          fill_we         = 1'b1;
          touch           = 1'b1;
          touch_way       = victim;
          bus.ready       = 1'b1;
          bus.output_data = bus.sram_read_data[32*wsel +: 32];
          state_d         = ST_IDLE;
        end
      end
      ST_WRITE: begin
        bus.sram_write_en = 1'b1;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q <= state_d;
      if (fill_we) valid_q[victim][idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_arr[victim][idx]  <= tag;
      data_arr[victim][idx] <= bus.sram_read_data;
    end
    if (wr_hit_we) data_arr[hit_way][idx][32*wsel +: 32] <= bus.write_data;
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        cnt_hit, cnt_miss;

  assign cnt_hit  = (state_q == ST_IDLE) && !bus.write_en && bus.read_en && hit;
  assign cnt_miss = (state_q == ST_IDLE) && (state_d == ST_FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (cnt_hit && hit_count_q != 32'hFFFF_FFFF)   hit_count_q  <= hit_count_q + 32'd1;
      if (cnt_miss && miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl (WAYS=2, SETS=64, LINE_WORDS=2) with a word-addressed
// SRAM model; CACHE_PERF_CNT_EN adds the counter checks.
module tb_set_assoc_cache_ctrl;
  import set_assoc_cache_ctrl_pkg::*;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_kind;   // 0: no SRAM op, 1: line fill, 2: write-through
    logic [31:0] exp_data;
    logic        gap;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  state_e state_dbg;
  int     n_checks = 0;
  int     n_pass   = 0;
  logic [31:0] mem [4096];
  vec_t   vecs [16];

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  set_assoc_cache_ctrl_if #(.LINE_WORDS(2)) bus ();

  set_assoc_cache_ctrl #(.WAYS(2), .SETS(64), .LINE_WORDS(2), .ADDR_W(19)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef CACHE_PERF_CNT_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Starts on a falling edge, ends on the falling edge after the completing rising edge.
  task automatic run_txn(input vec_t v, input int id);
    int   lat;
    bit   saw_rd, saw_wr, done;
    logic [11:0] w;
    bus.read_en    = !v.is_wr;
    bus.write_en   = v.is_wr;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    lat = 0; saw_rd = 0; saw_wr = 0; done = 0;
    w = {v.addr[13:3], 1'b0};
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus.sram_read_en) begin
        saw_rd = 1; lat++;
        if (lat == 1) chk($sformatf("v%0d fill addr", id), bus.sram_address, {v.addr[31:3], 3'b000});
        if (lat >= 3) begin
          bus.sram_read_data = {mem[w + 12'd1], mem[w]};
          bus.sram_ready     = 1'b1;
          #1;
        end
      end else if (bus.sram_write_en) begin
        saw_wr = 1; lat++;
        if (lat == 1) begin
          chk($sformatf("v%0d wr addr", id), bus.sram_address, v.addr);
          chk($sformatf("v%0d wr data", id), bus.sram_write_data, v.wdata);
        end
        if (lat >= 3) begin
          mem[v.addr[13:2]] = bus.sram_write_data;
          bus.sram_ready    = 1'b1;
          #1;
        end
      end
      if (bus.ready) begin
        done = 1;
        if (!v.is_wr) chk($sformatf("v%0d data", id), bus.output_data, v.exp_data);
        chk($sformatf("v%0d sram kind", id), saw_rd ? 32'd1 : (saw_wr ? 32'd2 : 32'd0),
            {30'd0, v.exp_kind});
      end
      @(posedge clk);
      @(negedge clk);
      bus.sram_ready = 1'b0;
    end
    if (!done) chk($sformatf("v%0d ready timeout", id), 32'd0, 32'd1);
    if (v.gap) begin
      bus.read_en  = 1'b0;
      bus.write_en = 1'b0;
      #1;
      chk($sformatf("v%0d ready pulse", id), {31'd0, bus.ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | (i << 2);
    mem[12'h040] = 32'hAAAA_AAAA;
    mem[12'h041] = 32'hBBBB_BBBB;

    vecs[0]  = '{1'b0, 32'h0000_0104, 32'h0,         2'd1, 32'hBBBB_BBBB, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         2'd0, 32'hAAAA_AAAA, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_0104, 32'h1234_5678, 2'd2, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0104, 32'h0,         2'd0, 32'h1234_5678, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         2'd1, 32'h5A00_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0200, 32'h0,         2'd1, 32'h5A00_0200, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         2'd0, 32'h5A00_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0,         2'd1, 32'h5A00_0400, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         2'd0, 32'h5A00_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0200, 32'h0,         2'd1, 32'h5A00_0200, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         2'd0, 32'h5A00_0000, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_0800, 32'hCAFE_F00D, 2'd2, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0800, 32'h0,         2'd1, 32'hCAFE_F00D, 1'b0};
    vecs[13] = '{1'b0, 32'h8000_0104, 32'h0,         2'd0, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_010C, 32'h0,         2'd1, 32'h5A00_010C, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0108, 32'h0,         2'd0, 32'h5A00_0108, 1'b1};

    rst = 1'b1;
    bus.read_en = 1'b0; bus.write_en = 1'b0; bus.address = '0; bus.write_data = '0;
    bus.sram_ready = 1'b0; bus.sram_read_data = '0;
    repeat (2) @(negedge clk);
    chk("rst ready",     {31'd0, bus.ready},         32'd0);
    chk("rst sram_rd",   {31'd0, bus.sram_read_en},  32'd0);
    chk("rst sram_wr",   {31'd0, bus.sram_write_en}, 32'd0);
    chk("rst out_data",  bus.output_data,            32'd0);
    chk("rst state",     {30'd0, state_dbg},         {30'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
`ifdef CACHE_PERF_CNT_EN
      if (i == 2) begin
        chk("perf hit_count",  hit_count,  32'd1);
        chk("perf miss_count", miss_count, 32'd1);
      end
`endif
      run_txn(vecs[i], i);
    end

    // sram_ready while idle must be ignored
    bus.sram_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle sram_ready state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    chk("idle sram_ready ready", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.sram_ready = 1'b0;

`ifdef CACHE_PERF_CNT_EN
    force dut.hit_count_q  = 32'hFFFF_FFFF;
    force dut.miss_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.hit_count_q;
    release dut.miss_count_q;
    run_txn(vecs[3], 100);
    chk("perf hit sat",  hit_count,  32'hFFFF_FFFF);
    chk("perf miss sat", miss_count, 32'hFFFF_FFFF);
`endif

    // Reset while a fill is outstanding aborts it at once
    bus.read_en = 1'b1; bus.write_en = 1'b0; bus.address = 32'h0000_0300;
    @(posedge clk);
    #1;
    chk("abort fill rd_en", {31'd0, bus.sram_read_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort rd_en drop", {31'd0, bus.sram_read_en}, 32'd0);
    chk("abort state",      {30'd0, state_dbg},        {30'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    bus.read_en = 1'b0;
    @(negedge clk);
    v = '{1'b0, 32'h0000_0100, 32'h0, 2'd1, 32'hAAAA_AAAA, 1'b1};
    run_txn(v, 101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
